// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and default sizes for the shift-register blocks.
package shift_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_AMTW  = 3;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/shift_cnt.sv
// shift_cnt: loadable down-counter that stops at zero and flags a count of one.
module shift_cnt #(
   parameter int AMTW = shift_pkg::DEF_AMTW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            dec,
   input  logic [AMTW-1:0] load_val,
   output logic            is_one
);
   logic [AMTW-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign is_one = cnt_q == AMTW'(1);
endmodule

// File: rtl/shift_right_unit.sv
// shift_right_unit: multi-cycle logical/arithmetic right shifter, one bit per cycle.
module shift_right_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AMTW  = DEF_AMTW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             arith,
   input  logic [AMTW-1:0]  amt,
   input  logic [WIDTH-1:0] d,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             arith_q, arith_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load, dec, cnt_is_one;
   shift_cnt #(.AMTW(AMTW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .dec      (dec),
      .load_val (amt),
      .is_one   (cnt_is_one)
   );
   // DONE accepts a new start just like IDLE so back-to-back requests lose no cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      arith_d = arith_q;
      load    = 1'b0;
      dec     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               data_d  = d;
               arith_d = arith;
               load    = 1'b1;
               state_d = (amt != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            data_d  = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
            dec     = 1'b1;
            state_d = cnt_is_one ? S_DONE : S_SHIFT;
         end
         default: begin
            state_d = S_IDLE;
            data_d  = '0;
            arith_d = 1'b0;
         end
      endcase
      busy_d = state_d == S_SHIFT;
      done_d = state_d == S_DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         arith_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         arith_q <= arith_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign q    = data_q;
endmodule

// File: tb/tb_shift_right_unit.sv
// tb_shift_right_unit: vector table plus corner-case sequences, scoreboard of expected q.
module tb_shift_right_unit;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       arith = 1'b0;
   logic [2:0] amt = '0;
   logic [7:0] d = '0;
   logic       busy, done;
   logic [7:0] q;
   int         vecs = 0;
   int         errs = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] d;
      logic [2:0] amt;
      logic       arith;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[10];

   shift_right_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .arith (arith),
      .amt   (amt),
      .d     (d),
      .busy  (busy),
      .done  (done),
      .q     (q)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      if (sb.size() == 0) begin
         check({name, " unexpected done"}, 1, 0);
      end else begin
         check({name, " q"}, q, sb.pop_front());
      end
   endtask

   // Starts one operation at the next edge, then waits for done; returns cycles and busy count.
   task automatic run_op(input logic [7:0] vd, input logic [2:0] va, input logic vr,
                         input logic [7:0] ve, output int lat, output int nb);
      @(negedge clk);
      start = 1'b1; d = vd; amt = va; arith = vr;
      sb.push_back(ve);
      @(negedge clk);
      start = 1'b0; d = 8'hXX;
      lat = 0; nb = 0;
      while (!done && lat < 40) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, nb, seen;
      tbl[0] = '{8'hB4, 3'd3, 1'b0, 8'h16};
      tbl[1] = '{8'hB4, 3'd3, 1'b1, 8'hF6};
      tbl[2] = '{8'h80, 3'd7, 1'b1, 8'hFF};
      tbl[3] = '{8'h5A, 3'd0, 1'b0, 8'h5A};
      tbl[4] = '{8'h80, 3'd7, 1'b0, 8'h01};
      tbl[5] = '{8'h7F, 3'd7, 1'b1, 8'h00};
      tbl[6] = '{8'h81, 3'd1, 1'b1, 8'hC0};
      tbl[7] = '{8'h01, 3'd1, 1'b0, 8'h00};
      tbl[8] = '{8'hC3, 3'd5, 1'b1, 8'hFE};
      tbl[9] = '{8'hE5, 3'd2, 1'b0, 8'h39};

      #1;
      check("reset q", q, 8'h00);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_op(tbl[i].d, tbl[i].amt, tbl[i].arith, tbl[i].exp, lat, nb);
         check($sformatf("vec%0d done seen", i), done, 1);
         check($sformatf("vec%0d latency", i), lat, tbl[i].amt);
         check($sformatf("vec%0d busy cycles", i), nb, tbl[i].amt);
         pop_check($sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d done width", i), done, 0);
      end
      repeat (3) @(negedge clk);
      check("idle hold q", q, 8'h39);

      // Second start while shifting must be ignored.
      @(negedge clk);
      start = 1'b1; d = 8'h80; amt = 3'd7; arith = 1'b0;
      sb.push_back(8'h01);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; d = 8'hFF; amt = 3'd1; arith = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 2;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("ignore latency", lat, 7);
      pop_check("ignore");
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("ignore extra done", seen, 0);

      // Start held through DONE loads the next operation back-to-back.
      @(negedge clk);
      start = 1'b1; d = 8'hB4; amt = 3'd1; arith = 1'b0;
      sb.push_back(8'h5A);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 40);
      pop_check("b2b first");
      d = 8'h0F; amt = 3'd2;
      sb.push_back(8'h03);
      @(negedge clk);
      start = 1'b0;
      check("b2b busy", busy, 1);
      @(negedge clk);
      check("b2b not yet done", done, 0);
      @(negedge clk);
      check("b2b done", done, 1);
      pop_check("b2b second");

      // Asynchronous reset mid-shift aborts without a done pulse.
      @(negedge clk);
      start = 1'b1; d = 8'hFF; amt = 3'd5; arith = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort busy before rst", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("abort q", q, 8'h00);
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("abort no done", seen, 0);
      check("scoreboard empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 Parameter WIDTH, default 8, data width of d and q.
REQ-002 Parameter AMTW, default 3, width of amt; the maximum shift is 2^AMTW-1.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  request strobe, sampled on posedge clk.
REQ-006 arith  in  1  0 = logical right shift (zero fill), 1 = arithmetic right shift (sign fill); sampled with start.
REQ-007 amt  in  AMTW  right-shift distance; sampled with start.
REQ-008 d  in  WIDTH  operand; sampled with start.
REQ-009 busy  out  1  high while shifting is in progress.
REQ-010 done  out  1  one-cycle pulse; q is valid in this cycle.
REQ-011 q  out  WIDTH  result register, driven directly from a flop.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; one-hot or binary encoding at implementer's choice.
REQ-013 IDLE: start=1 loads the data register with d and the counter with amt, and latches arith.
- Next state is SHIFT if amt!=0, else DONE.
REQ-014 SHIFT: each cycle shifts the data register right by exactly 1 bit and decrements the counter.
- Fill bit is the MSB when arith=1, else 0.
REQ-015 SHIFT: when the counter is 1 on the clock edge, the final shift is performed and next state is DONE.
REQ-016 Latency: for a start accepted on edge k, done is high in the cycle following edge k+amt.
- amt=0 gives done in the cycle following edge k, with q=d.
REQ-017 DONE lasts exactly one cycle; next state is IDLE, or a new load if start=1 (back-to-back accepted).
REQ-018 busy=1 exactly when state==SHIFT; done=1 exactly when state==DONE; both are registered, never combinational from inputs.
REQ-019 start while in SHIFT is ignored; d, amt and arith are not sampled, and the operation in flight is unaffected.
REQ-020 q holds the last result through IDLE until the next accepted start reloads it.
REQ-021 Shift of WIDTH-1 with arith=1 yields all bits equal to the original MSB; with arith=0 it yields {0..0, d[WIDTH-1]}.
REQ-022 The counter is AMTW bits wide and never wraps; it is only decremented in SHIFT, where it is nonzero.

Reset
REQ-023 rst=1 forces state=IDLE, q=0, counter=0, latched arith=0, busy=0 and done=0 immediately, independent of clk.
REQ-024 rst asserted during SHIFT or DONE aborts the operation; no done pulse is produced for it.
REQ-025 The first start is accepted on the first posedge clk after rst deasserts.

Structure
REQ-026 State encodings and default WIDTH/AMTW constants live in the shared package shift_pkg, also used by the left-shift register block.
REQ-027 One sub-module is natural: shift_cnt, an AMTW-bit loadable down-counter with a load/dec/is_one interface.
- The datapath and FSM stay in shift_right_unit.
REQ-028 No latches; every case statement has a default branch assigning safe values.

Verification
REQ-029 d=8'hB4, amt=3, arith=0, start 1 cycle -> busy high 3 cycles, then done 1 cycle with q=8'h16.
REQ-030 d=8'hB4, amt=3, arith=1 -> done after 3 shift cycles, q=8'hF6; d=8'h80, amt=7, arith=1 -> q=8'hFF.
REQ-031 d=8'h5A, amt=0 -> busy never asserts, done in the cycle after the start edge, q=8'h5A.
REQ-032 d=8'h80, amt=7, arith=0; second start with d=8'hFF, amt=1 two cycles later -> second start ignored, q=8'h01 at done.
REQ-033 start held high through the DONE cycle with d=8'h0F, amt=2 -> new operation loads, done 2 cycles later with q=8'h03.
REQ-034 rst pulsed mid-SHIFT (amt=5, after 2 shifts) -> q=0, busy=0, done=0 asynchronously; no done pulse for the aborted operation.
